// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external ALU.
// Each accepted request runs IDLE -> EXEC (grant) -> DONE (response), one op per 3 cycles.
module alu_arbiter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              src0,
  input  logic              src1,
  input  logic [DATA_W-1:0] opa0,
  input  logic [DATA_W-1:0] opa1,
  input  logic [DATA_W-1:0] imm0,
  input  logic [DATA_W-1:0] imm1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              alu_src,
  output logic [DATA_W-1:0] alu_opa,
  output logic [DATA_W-1:0] alu_imm,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid0,
  output logic              rsp_valid1,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic              src;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] imm;
  } op_t;

  state_t            state_q, state_d;
  logic              win_q, win_d;
  logic              last_q, last_d;
  logic              pick;
  op_t               op_d;
  logic              gnt0_d, gnt1_d, rv0_d, rv1_d, busy_d;
  logic [DATA_W-1:0] data_d;

  // Next-state, arbitration and next-output logic.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    pick    = 1'b0;
    op_d    = '{src: alu_src, opa: alu_opa, imm: alu_imm};
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    data_d  = rsp_data;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that was not granted last wins.
          pick    = (req0 && req1) ? ~last_q : req1;
          state_d = EXEC;
          win_d   = pick;
          last_d  = pick;
          op_d    = pick ? '{src: src1, opa: opa1, imm: imm1}
                         : '{src: src0, opa: opa0, imm: imm0};
          gnt0_d  = ~pick;
          gnt1_d  = pick;
        end
      end
      EXEC: begin
        state_d = DONE;
        data_d  = alu_result;
        rv0_d   = ~win_q;
        rv1_d   = win_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      last_q     <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_data   <= '0;
      alu_src    <= 1'b0;
      alu_opa    <= '0;
      alu_imm    <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_q     <= last_d;
      gnt0       <= gnt0_d;
      gnt1       <= gnt1_d;
      rsp_valid0 <= rv0_d;
      rsp_valid1 <= rv1_d;
      rsp_data   <= data_d;
      alu_src    <= op_d.src;
      alu_opa    <= op_d.opa;
      alu_imm    <= op_d.imm;
      busy       <= busy_d;
    end
  end

endmodule
